load_extend: RTL and testbench

Registered load-data alignment and extension unit for the MEM→WB path: selects the addressed byte, halfword or word from a memory read word and sign- or zero-extends it to the register width. It also performs the LWL/LWR partial-word merges against the old destination value. It is the parametrised, pipelined successor of the combinational 16-bit immediate extender. It adds a valid/ready handshake, a misalignment flag and a saturating error counter.

---
 rtl/load_extend.sv | 120 ++++++++++++
 tb/tb_load_extend.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/load_extend.sv
// Registered load alignment/extension unit for the MEM->WB path: byte/half/word
// select with sign/zero extension, LWL/LWR merges, error flag and saturating error count.
module load_extend #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [OFF_W-1:0]  in_offset,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              err_clr
);

    localparam int unsigned       SH_W    = OFF_W + 4;
    localparam logic [DATA_W-1:0] ONES    = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    localparam logic [2:0] M_LB  = 3'd0;
    localparam logic [2:0] M_LBU = 3'd1;
    localparam logic [2:0] M_LH  = 3'd2;
    localparam logic [2:0] M_LHU = 3'd3;
    localparam logic [2:0] M_LW  = 3'd4;
    localparam logic [2:0] M_LWL = 3'd5;
    localparam logic [2:0] M_LWR = 3'd6;

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              accept_c;
    logic [DATA_W-1:0] res_c;
    logic              err_c;
    logic [SH_W-1:0]   sh_lo;
    logic [SH_W-1:0]   sh_hi;
    logic [SH_W-1:0]   sh_lwl;
    logic [DATA_W-1:0] mem_shr;

    // Shift amounts: sh_lo = 8*o, sh_hi = 8*(o+1), sh_lwl = DATA_W - 8*(o+1)
    assign sh_lo   = SH_W'({in_offset, 3'b000});
    assign sh_hi   = sh_lo + SH_W'(8);
    assign sh_lwl  = SH_W'(DATA_W) - sh_hi;
    assign mem_shr = in_mem >> sh_lo;

    assign in_ready = !valid_q || out_ready;
    assign accept_c = in_valid && in_ready;

    // Lane select, extension and partial-word merge
    always_comb begin
        res_c = '0;
        err_c = 1'b0;
        case (in_mode)
            M_LB:  res_c = DATA_W'($signed(mem_shr[7:0]));
            M_LBU: res_c = DATA_W'(mem_shr[7:0]);
            M_LH: begin
                res_c = DATA_W'($signed(mem_shr[15:0]));
                err_c = in_offset[0];
            end
            M_LHU: begin
                res_c = DATA_W'(mem_shr[15:0]);
                err_c = in_offset[0];
            end
            M_LW: begin
                res_c = DATA_W'($signed(mem_shr[31:0]));
                err_c = |in_offset[1:0];
            end
            M_LWL: res_c = (in_mem << sh_lwl) | (in_rt & (ONES >> sh_hi));
            M_LWR: res_c = mem_shr | (in_rt & ~(ONES >> sh_lo));
            default: err_c = 1'b1;
        endcase
        if (err_c) begin
            res_c = '0;
        end
    end

    // Clear wins over increment; count saturates
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (accept_c && err_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept_c) begin
                valid_q <= 1'b1;
                data_q  <= res_c;
                err_q   <= err_c;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_err   = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_load_extend.sv
// Directed self-checking bench for load_extend: 32-bit, 2-bit-counter and 64-bit instances.
module tb_load_extend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mode;
    logic [2:0]  off;
    logic [63:0] mem;
    logic [63:0] rt;
    logic        out_ready;

    logic        v32, vc, v64;
    logic        clr32, clrc, clr64;
    logic        rdy32, rdyc, rdy64;
    logic        ov32, ovc, ov64;
    logic        oe32, oec, oe64;
    logic [31:0] od32, odc;
    logic [63:0] od64;
    logic [7:0]  cnt32, cnt64;
    logic [1:0]  cntc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_extend #(.DATA_W(32), .CNT_W(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .in_mode(mode),
        .in_offset(off[1:0]), .in_mem(mem[31:0]), .in_rt(rt[31:0]), .out_valid(ov32),
        .out_ready(out_ready), .out_data(od32), .out_err(oe32), .err_cnt(cnt32), .err_clr(clr32)
    );

    load_extend #(.DATA_W(32), .CNT_W(2)) uc (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_ready(rdyc), .in_mode(mode),
        .in_offset(off[1:0]), .in_mem(mem[31:0]), .in_rt(rt[31:0]), .out_valid(ovc),
        .out_ready(out_ready), .out_data(odc), .out_err(oec), .err_cnt(cntc), .err_clr(clrc)
    );

    load_extend #(.DATA_W(64), .CNT_W(8)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64), .in_mode(mode),
        .in_offset(off), .in_mem(mem), .in_rt(rt), .out_valid(ov64),
        .out_ready(out_ready), .out_data(od64), .out_err(oe64), .err_cnt(cnt64), .err_clr(clr64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one transfer to instance 'who' (0=u32, 1=uc, 2=u64) for one edge
    task automatic send(input int who, input logic [2:0] m, input logic [2:0] o,
                        input logic [63:0] d, input logic [63:0] r);
        mode = m; off = o; mem = d; rt = r;
        v32 = (who == 0); vc = (who == 1); v64 = (who == 2);
        @(posedge clk); #1;
        v32 = 1'b0; vc = 1'b0; v64 = 1'b0;
    endtask

    logic [31:0] words [8];

    initial begin
        rst_n = 1'b0; mode = '0; off = '0; mem = '0; rt = '0; out_ready = 1'b1;
        v32 = 1'b0; vc = 1'b0; v64 = 1'b0;
        clr32 = 1'b0; clrc = 1'b0; clr64 = 1'b0;
        words[0] = 32'h1111_0001; words[1] = 32'h2222_0002; words[2] = 32'h3333_0003;
        words[3] = 32'h4444_0004; words[4] = 32'h5555_0005; words[5] = 32'h6666_0006;
        words[6] = 32'h7777_0007; words[7] = 32'h8888_0008;

        #12;
        chk("rst_valid", 64'(ov32), 64'd0);
        chk("rst_data",  64'(od32), 64'd0);
        chk("rst_err",   64'(oe32), 64'd0);
        chk("rst_cnt",   64'(cnt32), 64'd0);
        chk("rst_ready", 64'(rdy32), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("idle_valid", 64'(ov32), 64'd0);
        send(0, 3'd0, 3'd1, 64'h8899AABB, 64'h0);
        chk("lb_valid", 64'(ov32), 64'd1);
        chk("lb_data",  64'(od32), 64'hFFFFFFAA);
        chk("lb_err",   64'(oe32), 64'd0);
        send(0, 3'd1, 3'd1, 64'h8899AABB, 64'h0);
        chk("lbu_data", 64'(od32), 64'h000000AA);
        chk("lbu_err",  64'(oe32), 64'd0);
        send(0, 3'd2, 3'd2, 64'h8899AABB, 64'h0);
        chk("lh_data",  64'(od32), 64'hFFFF8899);
        send(0, 3'd3, 3'd2, 64'h8899AABB, 64'h0);
        chk("lhu_data", 64'(od32), 64'h00008899);
        chk("cnt_pre",  64'(cnt32), 64'd0);
        send(0, 3'd2, 3'd1, 64'h8899AABB, 64'h0);
        chk("lh_mis_data", 64'(od32), 64'd0);
        chk("lh_mis_err",  64'(oe32), 64'd1);
        chk("lh_mis_cnt",  64'(cnt32), 64'd1);
        send(0, 3'd7, 3'd0, 64'h8899AABB, 64'h0);
        chk("rsv_err",  64'(oe32), 64'd1);
        chk("rsv_data", 64'(od32), 64'd0);
        chk("rsv_cnt",  64'(cnt32), 64'd2);
        send(0, 3'd4, 3'd0, 64'h8899AABB, 64'h0);
        chk("lw_data", 64'(od32), 64'h8899AABB);
        chk("lw_err",  64'(oe32), 64'd0);
        send(0, 3'd4, 3'd2, 64'h8899AABB, 64'h0);
        chk("lw_mis_err", 64'(oe32), 64'd1);
        send(0, 3'd5, 3'd1, 64'h8899AABB, 64'h11223344);
        chk("lwl1_data", 64'(od32), 64'hAABB3344);
        chk("lwl1_err",  64'(oe32), 64'd0);
        send(0, 3'd6, 3'd1, 64'h8899AABB, 64'h11223344);
        chk("lwr1_data", 64'(od32), 64'h118899AA);
        send(0, 3'd5, 3'd3, 64'h8899AABB, 64'h11223344);
        chk("lwl3_data", 64'(od32), 64'h8899AABB);
        send(0, 3'd6, 3'd0, 64'h8899AABB, 64'h11223344);
        chk("lwr0_data", 64'(od32), 64'h8899AABB);
        chk("cnt_after", 64'(cnt32), 64'd3);
        @(posedge clk); #1;
        chk("drain_valid", 64'(ov32), 64'd0);
        chk("drain_hold",  64'(od32), 64'h8899AABB);

        // Backpressure then streaming of 8 distinct words
        out_ready = 1'b0;
        mode = 3'd4; off = 3'd0; mem = 64'(words[0]); v32 = 1'b1;
        @(posedge clk); #1;
        mem = 64'(words[1]);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 64'(rdy32), 64'd0);
            chk("bp_data",  64'(od32), 64'(words[0]));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            chk("stream_valid", 64'(ov32), 64'd1);
            chk("stream_data",  64'(od32), 64'(words[i]));
            if (i < 7) mem = 64'(words[i + 1]);
            else       v32 = 1'b0;
        end
        @(posedge clk); #1;
        chk("stream_end_valid", 64'(ov32), 64'd0);
        chk("stream_end_data",  64'(od32), 64'(words[7]));

        // Saturating counter and clear priority on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            send(1, 3'd7, 3'd0, 64'h0, 64'h0);
            chk("sat_cnt", 64'(cntc), (i < 3) ? 64'(i + 1) : 64'd3);
        end
        chk("sat_err", 64'(oec), 64'd1);
        clrc = 1'b1;
        send(1, 3'd7, 3'd0, 64'h0, 64'h0);
        clrc = 1'b0;
        chk("clr_cnt", 64'(cntc), 64'd0);
        send(1, 3'd2, 3'd3, 64'h0, 64'h0);
        chk("post_clr_cnt", 64'(cntc), 64'd1);

        // Asynchronous reset while a result is pending
        send(1, 3'd1, 3'd0, 64'h000000C3, 64'h0);
        chk("pre_rst_valid", 64'(ovc), 64'd1);
        chk("pre_rst_data",  64'(odc), 64'h000000C3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ovc), 64'd0);
        chk("arst_data",  64'(odc), 64'd0);
        chk("arst_err",   64'(oec), 64'd0);
        chk("arst_cnt",   64'(cntc), 64'd0);
        chk("arst_ready", 64'(rdyc), 64'd1);
        chk("arst_cnt32", 64'(cnt32), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 64-bit instance
        send(2, 3'd4, 3'd4, 64'h0123456789ABCDEF, 64'h0);
        chk("w64_lw4",     od64, 64'h0000000001234567);
        chk("w64_lw4_err", 64'(oe64), 64'd0);
        send(2, 3'd4, 3'd0, 64'h0123456789ABCDEF, 64'h0);
        chk("w64_lw0", od64, 64'hFFFFFFFF89ABCDEF);
        send(2, 3'd4, 3'd2, 64'h0123456789ABCDEF, 64'h0);
        chk("w64_lw2_err",  64'(oe64), 64'd1);
        chk("w64_lw2_data", od64, 64'd0);
        chk("w64_cnt",      64'(cnt64), 64'd1);
        send(2, 3'd0, 3'd7, 64'h0123456789ABCDEF, 64'h0);
        chk("w64_lb7", od64, 64'h0000000000000001);
        send(2, 3'd2, 3'd6, 64'h0123456789ABCDEF, 64'h0);
        chk("w64_lh6", od64, 64'h0000000000000123);
        send(2, 3'd5, 3'd3, 64'h0123456789ABCDEF, 64'h1122334455667788);
        chk("w64_lwl3", od64, 64'h89ABCDEF55667788);
        send(2, 3'd6, 3'd5, 64'h0123456789ABCDEF, 64'h1122334455667788);
        chk("w64_lwr5", od64, 64'h1122334455012345);

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
